// File: rtl/paralelo_serial_tx_if.sv
// Word-side bundle between the divider/framer and paralelo_serial_tx (idle_cnt only with IDLE_COUNT_EN).
// The master drives clk4f/data_in/valid_in; the slave returns the serial stream and status pulses.
interface paralelo_serial_tx_if #(
   parameter int unsigned DATA_W = 8
);
   logic              clk4f;
   logic [DATA_W-1:0] data_in;
   logic              valid_in;
   logic              serial_out;
   logic              word_load;
   logic              data_taken;
   logic              align_err;
   logic              init_done;
`ifdef IDLE_COUNT_EN
   logic [15:0]       idle_cnt;
`endif

   modport master (
      output clk4f, data_in, valid_in,
      input  serial_out, word_load, data_taken, align_err, init_done
`ifdef IDLE_COUNT_EN
      , input idle_cnt
`endif
   );

   modport slave (
      input  clk4f, data_in, valid_in,
      output serial_out, word_load, data_taken, align_err, init_done
`ifdef IDLE_COUNT_EN
      , output idle_cnt
`endif
   );
endinterface

// File: rtl/paralelo_serial_tx.sv
// MSB-first serialiser: one word per clk4f rising edge, DATA_W bits at clk32f; optional idle_cnt via IDLE_COUNT_EN.
// First bit one cycle after word_load, last bit DATA_W cycles after; no backpressure, empty slots carry IDLE_WORD.
module paralelo_serial_tx #(
   parameter int unsigned       DATA_W     = 8,
   parameter logic [DATA_W-1:0] IDLE_WORD  = 8'hBC,
   parameter int unsigned       INIT_WORDS = 4
) (
   input  logic                clk32f,
   input  logic                rst,
   paralelo_serial_tx_if.slave bus
);

   localparam int unsigned BC_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam int unsigned IC_W = (INIT_WORDS > 1) ? $clog2(INIT_WORDS + 1) : 1;
   localparam logic [BC_W-1:0] BIT_LAST = BC_W'(DATA_W - 1);
   localparam logic [IC_W-1:0] INIT_MAX = IC_W'(INIT_WORDS);

   typedef enum logic [1:0] {
      SYNC = 2'd0,
      INIT = 2'd1,
      RUN  = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_clk4f_q;
   logic [DATA_W-1:0] r_shift;
   logic [DATA_W-1:0] w_shift_nxt;
   logic [BC_W-1:0]   r_bit_cnt;
   logic [BC_W-1:0]   w_bit_cnt_nxt;
   logic [IC_W-1:0]   r_init_cnt;
   logic [IC_W-1:0]   w_init_cnt_nxt;
   logic [IC_W-1:0]   w_init_cnt_inc;
   logic              r_serial_out;
   logic              w_serial_nxt;
   logic              r_word_load;
   logic              w_load;
   logic              r_data_taken;
   logic              w_taken;
   logic              r_align_err;
   logic              w_align;
   logic              r_init_done;
   logic              w_init_done_nxt;
   logic              w_idle_load;
   logic              w_bnd;
   logic              w_last_bit;
   logic              w_init_load;

   assign w_bnd          = bus.clk4f & ~r_clk4f_q;
   assign w_last_bit     = (r_bit_cnt == BIT_LAST);
   assign w_init_load    = (r_init_cnt < INIT_MAX);
   assign w_init_cnt_inc = r_init_cnt + 1'b1;

   always_ff @(posedge clk32f) begin
      if (rst) begin
         r_state <= SYNC;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_shift_nxt     = r_shift;
      w_bit_cnt_nxt   = r_bit_cnt;
      w_init_cnt_nxt  = r_init_cnt;
      w_serial_nxt    = 1'b0;
      w_load          = 1'b0;
      w_taken         = 1'b0;
      w_align         = 1'b0;
      w_init_done_nxt = r_init_done;
      w_idle_load     = 1'b0;

      unique case (r_state)
         SYNC: begin
            w_load = w_bnd;
         end
         INIT, RUN: begin
            w_serial_nxt = r_shift[DATA_W-1];
            if (w_bnd) begin
               // An early boundary still loads: we re-align to the divider rather than drop a word.
               w_load  = 1'b1;
               w_align = ~w_last_bit;
            end else if (w_last_bit) begin
               w_align      = 1'b1;
               w_serial_nxt = 1'b0;
               w_state_nxt  = SYNC;
            end else begin
               w_shift_nxt   = {r_shift[DATA_W-2:0], 1'b0};
               w_bit_cnt_nxt = r_bit_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nxt = SYNC;
         end
      endcase

      if (w_load) begin
         w_bit_cnt_nxt = '0;
         if (w_init_load) begin
            // Comma burst still pending: data is ignored until the last comma is loaded.
            w_shift_nxt    = IDLE_WORD;
            w_idle_load    = 1'b1;
            w_init_cnt_nxt = w_init_cnt_inc;
            if (w_init_cnt_inc == INIT_MAX) begin
               w_state_nxt     = RUN;
               w_init_done_nxt = 1'b1;
            end else begin
               w_state_nxt = INIT;
            end
         end else begin
            w_state_nxt     = RUN;
            w_init_done_nxt = 1'b1;
            if (bus.valid_in) begin
               w_shift_nxt = bus.data_in;
               w_taken     = 1'b1;
            end else begin
               w_shift_nxt = IDLE_WORD;
               w_idle_load = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk32f) begin
      if (rst) begin
         r_clk4f_q    <= 1'b0;
         r_shift      <= '0;
         r_bit_cnt    <= '0;
         r_init_cnt   <= '0;
         r_serial_out <= 1'b0;
         r_word_load  <= 1'b0;
         r_data_taken <= 1'b0;
         r_align_err  <= 1'b0;
         r_init_done  <= 1'b0;
      end else begin
         r_clk4f_q    <= bus.clk4f;
         r_shift      <= w_shift_nxt;
         r_bit_cnt    <= w_bit_cnt_nxt;
         r_init_cnt   <= w_init_cnt_nxt;
         r_serial_out <= w_serial_nxt;
         r_word_load  <= w_load;
         r_data_taken <= w_taken;
         r_align_err  <= w_align;
         r_init_done  <= w_init_done_nxt;
      end
   end

`ifdef IDLE_COUNT_EN
   logic [15:0] r_idle_cnt;

   always_ff @(posedge clk32f) begin
      if (rst) begin
         r_idle_cnt <= '0;
      end else if (w_idle_load && (r_idle_cnt != 16'hFFFF)) begin
         r_idle_cnt <= r_idle_cnt + 16'd1;
      end
   end

   assign bus.idle_cnt = r_idle_cnt;
`else
   logic w_unused_idle;
   assign w_unused_idle = w_idle_load;
`endif

   assign bus.serial_out = r_serial_out;
   assign bus.word_load  = r_word_load;
   assign bus.data_taken = r_data_taken;
   assign bus.align_err  = r_align_err;
   assign bus.init_done  = r_init_done;

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// Directed + randomized bench for paralelo_serial_tx against an edge-indexed reference model.
module tb_paralelo_serial_tx;
   localparam int         DW    = 8;
   localparam logic [7:0] IDLE  = 8'hBC;
   localparam int         NINIT = 4;

   logic clk32f = 1'b0;
   logic rst    = 1'b1;
   int   checks = 0;
   int   errors = 0;

   paralelo_serial_tx_if #(.DATA_W(DW)) bus ();

   paralelo_serial_tx #(
      .DATA_W(DW),
      .IDLE_WORD(IDLE),
      .INIT_WORDS(NINIT)
   ) dut (
      .clk32f(clk32f),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk32f = ~clk32f;

   // Model: n is the clk32f edge index, last_load the edge of the latest load.
   int         n         = 0;
   int         last_load = 0;
   int         commas    = 0;
   int         idle_loads = 0;
   bit         synced    = 1'b0;
   bit         done      = 1'b0;
   bit         prev_c4   = 1'b0;
   logic [7:0] word_q    = 8'h00;
   bit         e_ser, e_load, e_taken, e_align;

   task automatic model(input bit c4, input bit v, input logic [7:0] d, input bit r);
      bit bnd;
      int age;
      n++;
      e_ser = 0; e_load = 0; e_taken = 0; e_align = 0;
      if (r) begin
         synced = 0; done = 0; commas = 0; prev_c4 = 0; idle_loads = 0;
         return;
      end
      bnd     = c4 && !prev_c4;
      prev_c4 = c4;
      if (synced) begin
         age   = n - last_load;
         e_ser = word_q[DW-age];
         if (!bnd && age == DW) begin
            e_align = 1; synced = 0; e_ser = 0;
         end else if (bnd && age != DW) begin
            e_align = 1;
         end
      end
      if (bnd) begin
         e_load = 1; synced = 1; last_load = n;
         if (commas < NINIT) begin
            commas++;
            word_q = IDLE;
            idle_loads++;
            if (commas == NINIT) done = 1;
         end else begin
            done    = 1;
            e_taken = v;
            word_q  = v ? d : IDLE;
            if (!v) idle_loads++;
         end
      end
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s at edge %0d: observed=%0h expected=%0h", tag, n, obs, exp);
      end
   endtask

   task automatic step(input bit c4, input bit v, input logic [7:0] d, input bit r);
      rst          = r;
      bus.clk4f    = c4;
      bus.valid_in = v;
      bus.data_in  = d;
      model(c4, v, d, r);
      @(posedge clk32f);
      #1;
      chk("serial_out", {15'd0, bus.serial_out}, {15'd0, e_ser});
      chk("word_load",  {15'd0, bus.word_load},  {15'd0, e_load});
      chk("data_taken", {15'd0, bus.data_taken}, {15'd0, e_taken});
      chk("align_err",  {15'd0, bus.align_err},  {15'd0, e_align});
      chk("init_done",  {15'd0, bus.init_done},  {15'd0, done});
`ifdef IDLE_COUNT_EN
      chk("idle_cnt", bus.idle_cnt, 16'(idle_loads));
`endif
   endtask

   // One clk4f period of p clk32f cycles: high first, so its rising edge opens the period.
   task automatic word(input int p, input bit v, input logic [7:0] d);
      for (int i = 0; i < p; i++) step(i < (p + 1) / 2, v, d, 1'b0);
   endtask

   initial begin
      step(0, 0, 8'h00, 1);
      step(0, 0, 8'h00, 1);
      repeat (3) step(0, 0, 8'h00, 0);

      // Comma burst; valid data offered mid-burst must be ignored.
      word(8, 0, 8'h00);
      word(8, 1, 8'h55);
      word(8, 1, 8'h55);
      word(8, 0, 8'h00);

      word(8, 1, 8'hA5);
      word(8, 0, 8'h00);
      word(8, 1, 8'h00);
      word(8, 1, 8'hFF);
      word(8, 1, 8'h3C);
      word(8, 0, 8'h00);

      for (int k = 0; k < 16; k++) word(8, 1'($urandom_range(0, 1)), 8'($urandom));

      // Missing boundary: drop to SYNC, then resume without a new comma burst.
      repeat (12) step(0, 0, 8'h00, 0);
      word(8, 1, 8'h96);
      word(8, 0, 8'h00);

      // Early boundary re-aligns without leaving RUN.
      word(5, 1, 8'($urandom));
      word(8, 1, 8'h69);
      word(8, 0, 8'h00);

      // Reset mid-word at bit_cnt 3, then the full comma burst again.
      for (int i = 0; i < 4; i++) step(1, 1, 8'h77, 0);
      step(0, 0, 8'h00, 1);
      repeat (2) step(0, 0, 8'h00, 0);
      for (int k = 0; k < 6; k++) word(8, 1, 8'($urandom));

      for (int k = 0; k < 24; k++)
         word(int'($urandom_range(6, 10)), 1'($urandom_range(0, 1)), 8'($urandom));
      word(8, 0, 8'h00);
      word(8, 0, 8'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/paralelo_serial_tx.md
Name: paralelo_serial_tx

Overview:
- Downstream consumer of the clock-divider stage. Takes one parallel word per clk4f period and serialises it MSB-first at the clk32f bit rate.
- Everything runs in the clk32f domain. clk4f is sampled as a data input and its rising edge marks word boundaries (8 bit slots per clk4f period).
- After reset it sends a fixed number of comma (IDLE_WORD) words before accepting data. Any slot without valid data is filled with IDLE_WORD.

Parameters:
- DATA_W, 8, width of the parallel word; also the bit slots per word.
- IDLE_WORD, 8'hBC, comma/idle symbol sent when no valid data.
- INIT_WORDS, 4, number of IDLE_WORD symbols forced after reset before data is accepted.

Ports:
- clk32f, input, 1, bit clock; all logic on its rising edge.
- rst, input, 1, synchronous, active-high reset.
- clk4f, input, 1, word-rate clock from the divider, sampled as data.
- data_in, input, DATA_W, parallel word to transmit.
- valid_in, input, 1, data_in is valid for the current word boundary.
- serial_out, output, 1, serial bit stream, MSB first.
- word_load, output, 1, one-cycle pulse in the cycle a word is loaded.
- data_taken, output, 1, one-cycle pulse: data_in was accepted (not idle) at this load.
- align_err, output, 1, one-cycle pulse on word-boundary misalignment.
- init_done, output, 1, high once INIT_WORDS commas have been loaded.

Behaviour:
- Reset (rst=1 at a clk32f edge): serial_out=0, word_load=0, data_taken=0, align_err=0, init_done=0; shift register=0, bit_cnt=0, init_cnt=0, clk4f_q=0, state=SYNC. Reset applies mid-word; the current word is dropped.
- Boundary detect: clk4f_q registers clk4f each cycle. A boundary (bnd) is clk4f=1 && clk4f_q=0.
- State SYNC:
  - serial_out held 0.
  - On bnd: load a word, set bit_cnt=0, go to INIT (init_cnt<INIT_WORDS) or RUN.
- Load rule:
  - In INIT, the shift register gets IDLE_WORD, init_cnt increments, and valid_in is ignored (data_taken=0).
  - In RUN, it gets data_in when valid_in=1 (data_taken=1), else IDLE_WORD (data_taken=0).
  - word_load=1 on every load.
- Shifting: in INIT/RUN, each non-load cycle shifts left by one and increments bit_cnt. serial_out = shift register MSB, registered, so bit 7 of a word appears the cycle after its load. Latency from load to last bit = DATA_W cycles.
- Transitions:
  - INIT→RUN at the load where init_cnt reaches INIT_WORDS; init_done goes high in that cycle and stays high until reset.
  - Expected boundary is bit_cnt==DATA_W-1. bnd with bit_cnt==DATA_W-1 is a normal load.
  - bnd with bit_cnt!=DATA_W-1 → align_err=1, load the word anyway, bit_cnt=0 (re-align, stay in state).
  - bit_cnt==DATA_W-1 with no bnd → align_err=1, go to SYNC, serial_out=0, init_done unchanged.
  - Re-entry from SYNC after init_done=1 goes straight to RUN (no new comma burst).
- INIT_WORDS=0: the first load is already in RUN and init_done rises at that load.
- Simultaneous rst and bnd: rst wins.

Optional Feature:
- Macro IDLE_COUNT_EN.
- Defined: adds output idle_cnt (16 bits), reset to 0, incremented on every load of IDLE_WORD (including INIT), saturating at 16'hFFFF.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset, then regular clk4f (period 8 clk32f), valid_in=0 → 4 words 0xBC serialised as 1,0,1,1,1,1,0,0, word_load every 8 cycles, init_done rises at the 4th load.
- After init, data_in=8'hA5, valid_in=1 for one boundary → data_taken=1; serial_out 1,0,1,0,0,1,0,1 on the 8 cycles after load; then 0xBC.
- Back-to-back data 8'h00, 8'hFF, 8'h3C valid on consecutive boundaries → contiguous 24-bit stream with no gaps; three data_taken pulses.
- valid_in=1 during INIT with data 8'h55 → ignored: 0xBC sent, data_taken=0.
- clk4f held low for 12 cycles in RUN → align_err pulse at bit_cnt=7, serial_out=0 in SYNC; next clk4f edge resumes in RUN with no comma burst.
- rst asserted mid-word (bit_cnt=3) → next cycle all outputs 0, state SYNC, init_done=0; 4 commas resent after the next clk4f edge.
